// File: rtl/demux_116_tdm_pkg.sv
// rtl/demux_116_tdm_pkg.sv - shared constants and state encoding for the 1:16 TDM demultiplexer
// Purpose : slot geometry, slot-counter width and FSM state type used by
//           demux_116_tdm and demux_slot_ctr.
// Macro   : DEMUX_PARITY_EN adds a parity slot (index 16) and widens the slot counter by 1 bit.
package demux_116_tdm_pkg;
   localparam int N_SLOTS     = 16;
   localparam int IDX_W       = 4;
   localparam int PARITY_SLOT = 16;
`ifdef DEMUX_PARITY_EN
   localparam int SEL_W       = IDX_W + 1;
   localparam int LAST_SLOT   = PARITY_SLOT;
`else
   localparam int SEL_W       = IDX_W;
   localparam int LAST_SLOT   = N_SLOTS - 1;
`endif

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;
endpackage

// File: rtl/demux_slot_ctr.sv
// rtl/demux_slot_ctr.sv - slot counter with load-1, increment, wrap and terminal-count flag
// Purpose : tracks the slot the next valid beat is written to.
// Ports   : clk, rst_n (async active-low)
//           load1 - force slot to 1 (a start-of-frame beat has just been taken as slot 0)
//           inc   - advance slot; wraps to 0 when tc is high
//           slot  - current slot index (SEL_W bits)
//           tc    - slot is the last beat of a frame
// Macro   : DEMUX_PARITY_EN (via package) sets the terminal slot to the parity slot.
module demux_slot_ctr
   import demux_116_tdm_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load1,
   input  logic             inc,
   output logic [SEL_W-1:0] slot,
   output logic             tc
);

   assign tc = (slot == SEL_W'(LAST_SLOT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot <= '0;
      end else if (load1) begin
         slot <= SEL_W'(1);
      end else if (inc) begin
         slot <= tc ? '0 : slot + SEL_W'(1);
      end
   end

endmodule

// File: rtl/demux_116_tdm.sv
// rtl/demux_116_tdm.sv - receive-side 1:16 time-division demultiplexer
// Purpose : rebuilds 16-bit words from a serial stream (slot 0 first, framed by sof)
//           and presents them on registered outputs with a one-cycle frame strobe.
// Ports   : clk, rst_n (async active-low)
//           din, din_valid, sof - serial beat; sof marks slot 0 and is qualified by din_valid
//           o           - last complete frame, o[k] = bit of slot k
//           frame_valid - 1-cycle pulse, o updated on the same edge
//           slot        - index the next valid beat is written to
//           err         - 1-cycle pulse on a framing (or parity) error
// Macro   : DEMUX_PARITY_EN adds a 17th even-parity beat per frame.
module demux_116_tdm
   import demux_116_tdm_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               din,
   input  logic               din_valid,
   input  logic               sof,
   output logic [N_SLOTS-1:0] o,
   output logic               frame_valid,
   output logic [SEL_W-1:0]   slot,
   output logic               err
);

   state_t             state_q, state_d;
   logic [N_SLOTS-1:0] shadow_q;
   logic [N_SLOTS-1:0] o_d;
   logic [IDX_W-1:0]   wr_idx;
   logic               wr_bit;
   logic               ctr_load1, ctr_inc, slot_tc;
   logic               frame_done, err_d;

   demux_slot_ctr u_slot_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .load1 (ctr_load1),
      .inc   (ctr_inc),
      .slot  (slot),
      .tc    (slot_tc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      ctr_load1  = 1'b0;
      ctr_inc    = 1'b0;
      wr_bit     = 1'b0;
      wr_idx     = '0;
      frame_done = 1'b0;
      err_d      = 1'b0;
      // Without parity the final data beat bypasses the shadow straight into o.
      o_d        = {din, shadow_q[N_SLOTS-2:0]};
      case (state_q)
         ST_IDLE: begin
            if (din_valid && sof) begin
               ctr_load1 = 1'b1;
               wr_bit    = 1'b1;
               state_d   = ST_RUN;
            end
         end
         ST_RUN: begin
            if (din_valid) begin
               if (sof) begin
                  // Either a back-to-back frame (slot 0) or an early sof that resyncs.
                  ctr_load1 = 1'b1;
                  wr_bit    = 1'b1;
                  err_d     = (slot != '0);
               end else if (slot == '0) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  ctr_inc = 1'b1;
`ifdef DEMUX_PARITY_EN
                  if (slot_tc) begin
                     if (^{shadow_q, din} == 1'b0) begin
                        frame_done = 1'b1;
                        o_d        = shadow_q;
                     end else begin
                        err_d = 1'b1;
                     end
                  end else begin
                     wr_bit = 1'b1;
                     wr_idx = slot[IDX_W-1:0];
                  end
`else
                  wr_bit     = 1'b1;
                  wr_idx     = slot[IDX_W-1:0];
                  frame_done = slot_tc;
`endif
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q    <= '0;
         o           <= '0;
         frame_valid <= 1'b0;
         err         <= 1'b0;
      end else begin
         if (wr_bit) begin
            shadow_q[wr_idx] <= din;
         end
         if (frame_done) begin
            o <= o_d;
         end
         frame_valid <= frame_done;
         err         <= err_d;
      end
   end

endmodule

// File: tb/tb_demux_116_tdm.sv
// tb/tb_demux_116_tdm.sv - directed scoreboard bench for demux_116_tdm
module tb_demux_116_tdm;
   import demux_116_tdm_pkg::*;

`ifdef DEMUX_PARITY_EN
   localparam int FRAME_BEATS = 17;
`else
   localparam int FRAME_BEATS = 16;
`endif

   logic               clk = 1'b0;
   logic               rst_n;
   logic               din, din_valid, sof;
   logic [N_SLOTS-1:0] o;
   logic               frame_valid;
   logic [SEL_W-1:0]   slot;
   logic               err;

   int                 checks   = 0;
   int                 failures = 0;
   int                 err_seen = 0;
   int                 err_exp  = 0;
   int                 cyc      = 0;
   logic [15:0]        sb_q[$];

   demux_116_tdm dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .din         (din),
      .din_valid   (din_valid),
      .sof         (sof),
      .o           (o),
      .frame_valid (frame_valid),
      .slot        (slot),
      .err         (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard side: every frame strobe must match the oldest pushed word.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (err === 1'b1) err_seen++;
         if (frame_valid === 1'b1) begin
            check("sb_frame_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) check("sb_o", 32'(o), 32'(sb_q.pop_front()));
         end
      end
   end

   task automatic beat(input logic b, input logic s);
      din       = b;
      sof       = s;
      din_valid = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      din_valid = 1'b0;
      sof       = 1'b0;
      din       = 1'($urandom);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Sends beats lo..15 (sof on slot 0) plus the parity beat when enabled,
   // optionally with a one-cycle gap after each non-final beat.
   task automatic finish_frame(input logic [15:0] w, input int lo, input bit gap);
      for (int k = lo; k < FRAME_BEATS; k++) begin
         logic b;
         b = (k < 16) ? w[k] : ^w;
         if (k == FRAME_BEATS - 1) sb_q.push_back(w);
         beat(b, k == 0);
         if (gap && k < FRAME_BEATS - 1) begin
            idle(1);
            check("gap_slot", 32'(slot), 32'(k + 1));
         end
      end
      din_valid = 1'b0;
      sof       = 1'b0;
      check("frame_valid", 32'(frame_valid), 32'd1);
      check("frame_o", 32'(o), 32'(w));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      int t1, t2;
      rst_n = 1'b0; din = 1'b0; din_valid = 1'b0; sof = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_o", 32'(o), 32'd0);
      check("rst_fv", 32'(frame_valid), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_slot", 32'(slot), 32'd0);
      rst_n = 1'b1;
      idle(2);

      // 1: single frame
      finish_frame(16'hA5C3, 0, 1'b0);
      idle(1);
      check("t1_fv_pulse", 32'(frame_valid), 32'd0);
      check("t1_no_err", 32'(err_seen), 32'd0);

      // 2: back-to-back frames
      finish_frame(16'h1234, 0, 1'b0);
      t1 = cyc;
      finish_frame(16'hFFFF, 0, 1'b0);
      t2 = cyc;
      check("t2_spacing", 32'(t2 - t1), 32'(FRAME_BEATS));
      idle(2);

      // 3: early sof at slot 7
      for (int k = 0; k < 7; k++) beat(k[0], k == 0);
      beat(1'b1, 1'b1);
      err_exp++;
      check("t3_err", 32'(err), 32'd1);
      check("t3_slot", 32'(slot), 32'd1);
      check("t3_o_hold", 32'(o), 32'hFFFF);
      check("t3_no_fv", 32'(frame_valid), 32'd0);
      finish_frame(16'hBEEF, 1, 1'b0);
      idle(2);

      // 4: gaps between every beat
      finish_frame(16'h00F0, 0, 1'b1);
      idle(2);

      // 5: reset at slot 9
      for (int k = 0; k < 9; k++) beat(1'b1, k == 0);
      din_valid = 1'b0;
      check("t5_slot_pre", 32'(slot), 32'd9);
      rst_n = 1'b0;
      #1;
      check("t5_rst_o", 32'(o), 32'd0);
      check("t5_rst_slot", 32'(slot), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) beat(1'b1, 1'b0);
      din_valid = 1'b0;
      idle(1);
      check("t5_ignored_slot", 32'(slot), 32'd0);
      check("t5_ignored_o", 32'(o), 32'd0);
      finish_frame(16'h0F0F, 0, 1'b0);
      idle(2);

`ifdef DEMUX_PARITY_EN
      // 6: parity good then bad
      finish_frame(16'h0001, 0, 1'b0);
      idle(1);
      for (int k = 0; k < 16; k++) beat(k == 0, k == 0);
      beat(1'b0, 1'b0);
      din_valid = 1'b0;
      err_exp++;
      check("t6_par_err", 32'(err), 32'd1);
      check("t6_par_no_fv", 32'(frame_valid), 32'd0);
      check("t6_par_o", 32'(o), 32'h0001);
      check("t6_par_slot", 32'(slot), 32'd0);
      idle(2);
`endif

      check("sb_drained", 32'(sb_q.size()), 32'd0);
      check("err_count", 32'(err_seen), 32'(err_exp));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
